// File: rtl/decode_ex_stage.sv
// -----------------------------------------------------------------------------
// decode_ex_stage
//
// RV32I instruction-decode stage. Decodes the instruction held in the IF/ID
// register into the ALU operation code, immediate, register indices and
// control bits used by the execute stage, and registers them into the ID/EX
// pipeline register. Also detects load-use hazards and inserts one bubble.
//
// Parameters
//   OP_W       width of the ALU operation code (encoding fixed below)
//   HAZARD_EN  1 = load-use detection and bubble insertion enabled
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   instr_d, pc_d   instruction word and its PC from IF/ID
//   valid_d         instr_d holds a real instruction
//   stall_e         downstream stall: hold the ID/EX register
//   flush_e         branch taken: kill the instruction being decoded
//   hazard_stall    combinational request for fetch to hold IF/ID
//   alu_op_e        ALU operation code (0 = idle)
//   alu_en_e        ALU operation valid
//   alu_src_imm_e   operand 2 select (1 = imm_e, 0 = rs2 data)
//   imm_e           decoded immediate
//   rs1_e/rs2_e/rd_e register indices
//   reg_we_e        writeback enable
//   mem_re_e        load
//   mem_we_e        store
//   pc_e            PC of the instruction in E
//   illegal_e       undecodable instruction
//   valid_e         E holds a real instruction
// -----------------------------------------------------------------------------
module decode_ex_stage #(
  parameter int OP_W      = 5,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_d,
  input  logic [31:0]     pc_d,
  input  logic            valid_d,
  input  logic            stall_e,
  input  logic            flush_e,
  output logic            hazard_stall,
  output logic [OP_W-1:0] alu_op_e,
  output logic            alu_en_e,
  output logic            alu_src_imm_e,
  output logic [31:0]     imm_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic            reg_we_e,
  output logic            mem_re_e,
  output logic            mem_we_e,
  output logic [31:0]     pc_e,
  output logic            illegal_e,
  output logic            valid_e
);

  // Major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation codes
  localparam logic [OP_W-1:0] OP_IDLE  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(21);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(22);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(24);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(25);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(26);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(27);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(28);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(29);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(30);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(31);

  // Immediate extraction, one function per instruction format.
  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_sh(input logic [31:0] ins);
    return {27'b0, ins[24:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: combinational decode of instr_d
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode_p0;
  logic [2:0]      funct3_p0;
  logic [6:0]      funct7_p0;
  logic [4:0]      rs1_p0;
  logic [4:0]      rs2_p0;
  logic [4:0]      rd_p0;
  logic [OP_W-1:0] op_p0;
  logic            legal_p0;
  logic            src_imm_p0;
  logic [31:0]     imm_p0;
  logic            wb_p0;
  logic            ld_p0;
  logic            st_p0;
  logic            uses_rs2_p0;
  logic            load_use_p0;
  logic            bubble_p0;

  assign opcode_p0 = instr_d[6:0];
  assign rd_p0     = instr_d[11:7];
  assign funct3_p0 = instr_d[14:12];
  assign rs1_p0    = instr_d[19:15];
  assign rs2_p0    = instr_d[24:20];
  assign funct7_p0 = instr_d[31:25];

  always_comb begin
    op_p0      = OP_IDLE;
    legal_p0   = 1'b0;
    src_imm_p0 = 1'b0;
    imm_p0     = 32'd0;
    wb_p0      = 1'b0;
    ld_p0      = 1'b0;
    st_p0      = 1'b0;
    case (opcode_p0)
      OPC_R: begin
        legal_p0 = 1'b1;
        wb_p0    = 1'b1;
        case (funct3_p0)
          3'b000: begin
            if (funct7_p0 == F7_ZERO)     op_p0 = OP_ADD;
            else if (funct7_p0 == F7_ALT) op_p0 = OP_SUB;
            else                          legal_p0 = 1'b0;
          end
          3'b101: begin
            if (funct7_p0 == F7_ZERO)     op_p0 = OP_SRL;
            else if (funct7_p0 == F7_ALT) op_p0 = OP_SRA;
            else                          legal_p0 = 1'b0;
          end
          3'b111: if (funct7_p0 == F7_ZERO) op_p0 = OP_AND;  else legal_p0 = 1'b0;
          3'b110: if (funct7_p0 == F7_ZERO) op_p0 = OP_OR;   else legal_p0 = 1'b0;
          3'b100: if (funct7_p0 == F7_ZERO) op_p0 = OP_XOR;  else legal_p0 = 1'b0;
          3'b010: if (funct7_p0 == F7_ZERO) op_p0 = OP_SLT;  else legal_p0 = 1'b0;
          3'b011: if (funct7_p0 == F7_ZERO) op_p0 = OP_SLTU; else legal_p0 = 1'b0;
          3'b001: if (funct7_p0 == F7_ZERO) op_p0 = OP_SLL;  else legal_p0 = 1'b0;
        endcase
      end
      OPC_IALU: begin
        legal_p0   = 1'b1;
        wb_p0      = 1'b1;
        src_imm_p0 = 1'b1;
        imm_p0     = imm_i(instr_d);
        case (funct3_p0)
          3'b000: op_p0 = OP_ADDI;
          3'b111: op_p0 = OP_ANDI;
          3'b110: op_p0 = OP_ORI;
          3'b100: op_p0 = OP_XORI;
          3'b010: op_p0 = OP_SLTI;
          3'b011: op_p0 = OP_SLTIU;
          // Shift-immediates carry a 5-bit shamt; the upper field selects
          // arithmetic vs logical right shift and is otherwise reserved.
          3'b101: begin
            imm_p0 = imm_sh(instr_d);
            if (funct7_p0 == F7_ZERO)     op_p0 = OP_SRLI;
            else if (funct7_p0 == F7_ALT) op_p0 = OP_SRAI;
            else                          legal_p0 = 1'b0;
          end
          3'b001: begin
            imm_p0 = imm_sh(instr_d);
            if (funct7_p0 == F7_ZERO) op_p0 = OP_SLLI;
            else                      legal_p0 = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        // Upper immediate left unshifted; the ALU applies the <<12.
        legal_p0   = 1'b1;
        wb_p0      = 1'b1;
        src_imm_p0 = 1'b1;
        op_p0      = OP_LUI;
        imm_p0     = {12'b0, instr_d[31:12]};
      end
      OPC_AUIPC: begin
        legal_p0   = 1'b1;
        wb_p0      = 1'b1;
        src_imm_p0 = 1'b1;
        op_p0      = OP_AUIPC;
        imm_p0     = {instr_d[31:12], 12'b0};
      end
      OPC_JAL: begin
        legal_p0   = 1'b1;
        wb_p0      = 1'b1;
        src_imm_p0 = 1'b1;
        op_p0      = OP_JAL;
        imm_p0     = imm_j(instr_d);
      end
      OPC_JALR: begin
        legal_p0   = (funct3_p0 == 3'b000);
        wb_p0      = 1'b1;
        src_imm_p0 = 1'b1;
        op_p0      = OP_JALR;
        imm_p0     = imm_i(instr_d);
      end
      OPC_LOAD: begin
        legal_p0   = (funct3_p0 == 3'b010);
        wb_p0      = 1'b1;
        ld_p0      = 1'b1;
        src_imm_p0 = 1'b1;
        op_p0      = OP_LW;
        imm_p0     = imm_i(instr_d);
      end
      OPC_STORE: begin
        legal_p0   = (funct3_p0 == 3'b010);
        st_p0      = 1'b1;
        src_imm_p0 = 1'b1;
        op_p0      = OP_SW;
        imm_p0     = imm_s(instr_d);
      end
      OPC_BRANCH: begin
        legal_p0 = 1'b1;
        imm_p0   = imm_b(instr_d);
        case (funct3_p0)
          3'b000:  op_p0 = OP_BEQ;
          3'b001:  op_p0 = OP_BNE;
          3'b100:  op_p0 = OP_BLT;
          3'b101:  op_p0 = OP_BGE;
          3'b110:  op_p0 = OP_BLTU;
          3'b111:  op_p0 = OP_BGEU;
          default: legal_p0 = 1'b0;
        endcase
      end
      default: ;
    endcase
    // An undecodable word must not reach the ALU, regfile or memory.
    if (!legal_p0) begin
      op_p0      = OP_IDLE;
      src_imm_p0 = 1'b0;
      imm_p0     = 32'd0;
      wb_p0      = 1'b0;
      ld_p0      = 1'b0;
      st_p0      = 1'b0;
    end
  end

  // rs2 comparison only matters for formats that actually read rs2.
  assign uses_rs2_p0 = (opcode_p0 == OPC_R) || (opcode_p0 == OPC_STORE) ||
                       (opcode_p0 == OPC_BRANCH);

  assign load_use_p0 = valid_d && valid_e && mem_re_e && (rd_e != 5'd0) &&
                       ((rd_e == rs1_p0) || (uses_rs2_p0 && (rd_e == rs2_p0)));

  // Once the bubble is in E, valid_e drops and the request clears, so each
  // load-use pair costs exactly one cycle.
  assign hazard_stall = HAZARD_EN ? (load_use_p0 && !flush_e && !stall_e) : 1'b0;

  // Flush beats stall; otherwise a stall holds E untouched.
  assign bubble_p0 = flush_e || (!stall_e && (hazard_stall || !valid_d));

  // ---------------------------------------------------------------------------
  // Stage e: ID/EX pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble_p0) begin
      alu_op_e      <= OP_IDLE;
      alu_en_e      <= 1'b0;
      alu_src_imm_e <= 1'b0;
      imm_e         <= 32'd0;
      rs1_e         <= 5'd0;
      rs2_e         <= 5'd0;
      rd_e          <= 5'd0;
      reg_we_e      <= 1'b0;
      mem_re_e      <= 1'b0;
      mem_we_e      <= 1'b0;
      pc_e          <= 32'd0;
      illegal_e     <= 1'b0;
      valid_e       <= 1'b0;
    end else if (!stall_e) begin
      alu_op_e      <= op_p0;
      alu_en_e      <= legal_p0;
      alu_src_imm_e <= src_imm_p0;
      imm_e         <= imm_p0;
      rs1_e         <= rs1_p0;
      rs2_e         <= rs2_p0;
      rd_e          <= rd_p0;
      reg_we_e      <= wb_p0 && (rd_p0 != 5'd0);
      mem_re_e      <= ld_p0;
      mem_we_e      <= st_p0;
      pc_e          <= pc_d;
      illegal_e     <= !legal_p0;
      valid_e       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_ex_stage.sv
module tb_decode_ex_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic        stall_e;
  logic        flush_e;

  logic        hazard_stall;
  logic [4:0]  alu_op_e;
  logic        alu_en_e;
  logic        alu_src_imm_e;
  logic [31:0] imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        reg_we_e, mem_re_e, mem_we_e;
  logic [31:0] pc_e;
  logic        illegal_e, valid_e;

  // Second instance with hazard detection disabled
  logic        hazard_stall0;
  logic [4:0]  alu_op0;
  logic        alu_en0, alu_src_imm0;
  logic [31:0] imm0;
  logic [4:0]  rs1_0, rs2_0, rd_0;
  logic        reg_we0, mem_re0, mem_we0;
  logic [31:0] pc0;
  logic        illegal0, valid0;

  decode_ex_stage #(.OP_W(5), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .hazard_stall(hazard_stall),
    .alu_op_e(alu_op_e), .alu_en_e(alu_en_e), .alu_src_imm_e(alu_src_imm_e),
    .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .reg_we_e(reg_we_e), .mem_re_e(mem_re_e), .mem_we_e(mem_we_e),
    .pc_e(pc_e), .illegal_e(illegal_e), .valid_e(valid_e)
  );

  decode_ex_stage #(.OP_W(5), .HAZARD_EN(1'b0)) dut_nohaz (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .hazard_stall(hazard_stall0),
    .alu_op_e(alu_op0), .alu_en_e(alu_en0), .alu_src_imm_e(alu_src_imm0),
    .imm_e(imm0), .rs1_e(rs1_0), .rs2_e(rs2_0), .rd_e(rd_0),
    .reg_we_e(reg_we0), .mem_re_e(mem_re0), .mem_we_e(mem_we0),
    .pc_e(pc0), .illegal_e(illegal0), .valid_e(valid0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model of the E register contents
  typedef struct packed {
    logic [4:0]  op;
    logic        en, src, we, re, wr, ill, vld;
    logic [31:0] imm, pc;
    logic [4:0]  rs1, rs2, rd;
  } e_t;

  // Decode table: fmt 0=R 1=I 2=shift-imm 3=S 4=B 5=J 6=LUI 7=AUIPC
  typedef struct { int opc; int f3; int f7; int op; int fmt; } rule_t;
  rule_t rules[$];

  int   tests = 0;
  int   fails = 0;
  e_t   m;
  bit   mz;
  bit   hz_obs;
  bit   hz_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic e_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    e_t r;
    int fmt;
    int opc, f3, f7, v;
    r = '0;
    fmt = -1;
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    foreach (rules[k]) begin
      if (fmt < 0 && rules[k].opc == opc && (rules[k].f3 < 0 || rules[k].f3 == f3) &&
          (rules[k].f7 < 0 || rules[k].f7 == f7)) begin
        fmt  = rules[k].fmt;
        r.op = 5'(rules[k].op);
      end
    end
    r.vld = 1'b1;
    r.pc  = pc;
    if (fmt < 0) begin
      r.ill = 1'b1;
      return r;
    end
    r.en  = 1'b1;
    r.rs1 = ins[19:15];
    r.rs2 = ins[24:20];
    r.rd  = ins[11:7];
    r.src = !(fmt == 0 || fmt == 4);
    r.we  = !(fmt == 3 || fmt == 4) && (ins[11:7] != 5'd0);
    r.re  = (r.op == 5'd21);
    r.wr  = (r.op == 5'd22);
    case (fmt)
      1: v = sext(int'(ins[31:20]), 12);
      2: v = int'(ins[24:20]);
      3: v = sext(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
      4: v = sext(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
                  int'(ins[11:8]) * 2, 13);
      5: v = sext(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 +
                  int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21);
      6: v = int'(ins >> 12);
      7: v = int'(ins & 32'hFFFFF000);
      default: v = 0;
    endcase
    r.imm = 32'(v);
    return r;
  endfunction

  function automatic bit ref_hazard(input logic [31:0] ins, input bit v, input bit st, input bit fl);
    bit uses2;
    uses2 = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
    return v && m.vld && m.re && (m.rd != 0) &&
           ((m.rd == ins[19:15]) || (uses2 && m.rd == ins[24:20])) && !fl && !st;
  endfunction

  task automatic check_e();
    chk("valid_e",   32'(valid_e),   32'(m.vld));
    chk("alu_op_e",  32'(alu_op_e),  32'(m.op));
    chk("alu_en_e",  32'(alu_en_e),  32'(m.en));
    chk("reg_we_e",  32'(reg_we_e),  32'(m.we));
    chk("mem_re_e",  32'(mem_re_e),  32'(m.re));
    chk("mem_we_e",  32'(mem_we_e),  32'(m.wr));
    chk("illegal_e", 32'(illegal_e), 32'(m.ill));
    if (m.vld) chk("pc_e", pc_e, m.pc);
    if (!m.ill) chk("alu_src_imm_e", 32'(alu_src_imm_e), 32'(m.src));
    if (m.vld && !m.ill) begin
      chk("imm_e", imm_e, m.imm);
      chk("rs1_e", 32'(rs1_e), 32'(m.rs1));
      chk("rs2_e", 32'(rs2_e), 32'(m.rs2));
      chk("rd_e",  32'(rd_e),  32'(m.rd));
    end
    if (mz) begin
      chk("zero_imm", imm_e, 32'd0);
      chk("zero_pc",  pc_e,  32'd0);
      chk("zero_rd",  32'(rd_e), 32'd0);
    end
  endtask

  // One clock of stimulus: drive, check hazard, advance model, check E.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input bit v,
                      input bit st, input bit fl);
    e_t nx;
    bit z;
    instr_d = ins; pc_d = pc; valid_d = v; stall_e = st; flush_e = fl;
    hz_exp = ref_hazard(ins, v, st, fl);
    #1;
    hz_obs = hazard_stall;
    chk("hazard_stall", 32'(hazard_stall), 32'(hz_exp));
    chk("hazard_stall_disabled", 32'(hazard_stall0), 32'd0);
    z = 1'b0;
    if (fl) begin nx = '0; z = 1'b1; end
    else if (st) nx = m;
    else if (hz_exp || !v) nx = '0;
    else nx = ref_decode(ins, pc);
    @(posedge clk);
    #1;
    m  = nx;
    mz = z;
    check_e();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] opcs [9];
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    int sel;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
    sel = int'($urandom_range(0, 11));
    if (sel < 9) opc = opcs[sel];
    else if (sel == 9) opc = 7'h03;
    else opc = 7'($urandom);
    f3 = 3'($urandom);
    if ((opc == 7'h03 || opc == 7'h23) && $urandom_range(0, 3) != 0) f3 = 3'd2;
    sel = int'($urandom_range(0, 3));
    f7 = (sel < 2) ? 7'h00 : (sel == 2) ? 7'h20 : 7'($urandom);
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
            5'($urandom_range(0, 3)), opc};
  endfunction

  initial begin
    logic [31:0] ins, pc;
    bit v, st, fl;

    rules.push_back('{'h33, 0, 'h00, 1, 0});  rules.push_back('{'h33, 0, 'h20, 2, 0});
    rules.push_back('{'h33, 7, 'h00, 3, 0});  rules.push_back('{'h33, 6, 'h00, 4, 0});
    rules.push_back('{'h33, 4, 'h00, 5, 0});  rules.push_back('{'h33, 2, 'h00, 6, 0});
    rules.push_back('{'h33, 3, 'h00, 7, 0});  rules.push_back('{'h33, 5, 'h20, 8, 0});
    rules.push_back('{'h33, 5, 'h00, 9, 0});  rules.push_back('{'h33, 1, 'h00, 10, 0});
    rules.push_back('{'h13, 0, -1, 11, 1});   rules.push_back('{'h13, 7, -1, 12, 1});
    rules.push_back('{'h13, 6, -1, 13, 1});   rules.push_back('{'h13, 4, -1, 14, 1});
    rules.push_back('{'h13, 2, -1, 15, 1});   rules.push_back('{'h13, 3, -1, 16, 1});
    rules.push_back('{'h13, 5, 'h20, 17, 2}); rules.push_back('{'h13, 5, 'h00, 18, 2});
    rules.push_back('{'h13, 1, 'h00, 19, 2});
    rules.push_back('{'h37, -1, -1, 20, 6});  rules.push_back('{'h03, 2, -1, 21, 1});
    rules.push_back('{'h23, 2, -1, 22, 3});
    rules.push_back('{'h63, 0, -1, 23, 4});   rules.push_back('{'h63, 1, -1, 24, 4});
    rules.push_back('{'h63, 4, -1, 25, 4});   rules.push_back('{'h63, 5, -1, 26, 4});
    rules.push_back('{'h63, 6, -1, 27, 4});   rules.push_back('{'h63, 7, -1, 28, 4});
    rules.push_back('{'h17, -1, -1, 29, 7});  rules.push_back('{'h6F, -1, -1, 30, 5});
    rules.push_back('{'h67, 0, -1, 31, 1});

    instr_d = 32'd0; pc_d = 32'd0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    m = '0; mz = 1'b1;
    check_e();
    chk("reset_hazard", 32'(hazard_stall), 32'd0);
    rst = 1'b0;

    // Directed decode checks
    step(32'h002081B3, 32'h100, 1, 0, 0);
    chk("add_op", 32'(alu_op_e), 32'd1);
    step(32'h402081B3, 32'h104, 1, 0, 0);
    chk("sub_op", 32'(alu_op_e), 32'd2);
    step(32'hFFF00293, 32'h108, 1, 0, 0);
    chk("addi_imm", imm_e, 32'hFFFFFFFF);
    step(32'h123450B7, 32'h10C, 1, 0, 0);
    chk("lui_imm", imm_e, 32'h00012345);

    // Load-use: one bubble, then the dependent ADD
    step(32'h0080A303, 32'h110, 1, 0, 0);
    chk("lw_op", 32'(alu_op_e), 32'd21);
    step(32'h001303B3, 32'h114, 1, 0, 0);
    chk("lu_hazard_seen", 32'(hz_obs), 32'd1);
    chk("lu_bubble", 32'(valid_e), 32'd0);
    chk("nohaz_add_in_e", 32'(alu_op0), 32'd1);
    step(32'h001303B3, 32'h114, 1, 0, 0);
    chk("lu_hazard_clear", 32'(hz_obs), 32'd0);
    chk("lu_add_op", 32'(alu_op_e), 32'd1);

    // Illegal word
    step(32'hFFFFFFFF, 32'h118, 1, 0, 0);
    chk("illegal_flag", 32'(illegal_e), 32'd1);

    // Stall holds, flush with stall clears
    step(32'h002081B3, 32'h11C, 1, 0, 0);
    step(32'h402081B3, 32'h120, 1, 1, 0);
    chk("stall_hold", 32'(alu_op_e), 32'd1);
    step(32'h402081B3, 32'h120, 1, 1, 1);
    chk("flush_stall", 32'(valid_e), 32'd0);

    // Async reset while stalled
    step(32'h0080A303, 32'h124, 1, 0, 0);
    stall_e = 1'b1;
    #2 rst = 1'b1;
    #1;
    m = '0; mz = 1'b1;
    check_e();
    @(posedge clk);
    #1 rst = 1'b0;
    stall_e = 1'b0;

    // Randomized traffic; fetch holds IF/ID on hazard or stall
    ins = rnd_instr(); pc = 32'h200; v = 1;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step(ins, pc, v, st, fl);
      if (!(hz_exp || st) || fl) begin
        ins = rnd_instr();
        pc  = pc + 32'd4;
        v   = ($urandom_range(0, 7) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
